sqrt_modport: RTL and testbench



---
 rtl/sqrt_modport_pkg.sv | 14 +
 rtl/sqrt_stage.sv | 25 ++
 rtl/sqrt_modport.sv | 37 +++
 tb/tb_sqrt_modport.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sqrt_modport_pkg.sv
// sqrt_modport_pkg: shared widths and the per-stage pipeline record for the square-root unit.
package sqrt_modport_pkg;

    localparam int W       = 8;
    localparam int FRAC_W  = W / 2;
    localparam int LATENCY = W;

    typedef struct packed {
        logic [W+1:0]   remainder;
        logic [W-1:0]   root;
        logic [2*W-1:0] radicand;
    } stage_t;

endpackage

// File: rtl/sqrt_stage.sv
// sqrt_stage: one restoring digit-by-digit iteration producing root bit W-1-K.
module sqrt_stage
    import sqrt_modport_pkg::*;
#(
    parameter int K = 0
) (
    input  stage_t s_in,
    output stage_t s_out
);

    logic [W+3:0] rem_sh;
    logic [W+3:0] trial;
    logic         ge;

    always_comb begin
        rem_sh = {s_in.remainder, s_in.radicand[2*W-1-2*K -: 2]};
        trial  = {2'b00, s_in.root, 2'b01};
        ge     = rem_sh >= trial;
        // The kept remainder never exceeds 2*root, so the low W+2 bits of the difference are exact.
        s_out.remainder = ge ? rem_sh[W+1:0] - trial[W+1:0] : rem_sh[W+1:0];
        s_out.root      = {s_in.root[W-2:0], ge};
        s_out.radicand  = s_in.radicand;
    end

endmodule

// File: rtl/sqrt_modport.sv
// sqrt_modport: fully pipelined Q4.4 square root of an 8-bit integer, one result per clock.
module sqrt_modport
    import sqrt_modport_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out
);

    stage_t stage_in [W];
    stage_t stage_d  [W];
    stage_t stage_q  [W];

    always_comb begin
        stage_in[0] = '{remainder: '0, root: '0, radicand: {data_in, {W{1'b0}}}};
        for (int i = 1; i < W; i++) stage_in[i] = stage_q[i-1];
    end

    for (genvar k = 0; k < W; k++) begin : g_stage
        sqrt_stage #(.K(k)) u_stage (
            .s_in  (stage_in[k]),
            .s_out (stage_d[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < W; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign data_out = stage_q[W-1].root;

endmodule

// File: tb/tb_sqrt_modport.sv
// tb_sqrt_modport: directed and exhaustive checks of sqrt_modport against a delay-line model.
module tb_sqrt_modport;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$] = '{0, 0, 0, 0, 0, 0, 0, 0};

    sqrt_modport dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int v;
        int r;
        v = x * 256;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: results leave W edges after the sample was taken; reset empties the line.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) exp_q[i] = 0;
        end else begin
            exp_q.push_back(isqrt(int'(data_in)));
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) check("model", data_out, 8'(exp_q[0]));

    task automatic hold(input logic [W-1:0] x, input logic [W-1:0] prev, input logic [W-1:0] exp);
        data_in = x;
        repeat (7) @(negedge clk);
        check("latency_prev", data_out, prev);
        @(negedge clk);
        check("latency_new", data_out, exp);
    endtask

    logic [W-1:0] s_in  [6] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd16, 8'd255};
    logic [W-1:0] s_out [6] = '{8'h00, 8'h10, 8'h16, 8'h20, 8'h40, 8'hFF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        data_in = 8'hAA;
        check("pin_2", 8'(isqrt(2)), 8'h16);
        check("pin_3", 8'(isqrt(3)), 8'h1B);
        check("pin_100", 8'(isqrt(100)), 8'hA0);
        check("pin_255", 8'(isqrt(255)), 8'hFF);
        repeat (5) begin
            @(negedge clk);
            check("reset_hold", data_out, 8'h00);
        end
        reset_n = 1'b1;
        data_in = 8'h00;
        repeat (7) @(negedge clk);
        check("reset_flush", data_out, 8'h00);
        hold(8'd1,   8'h00, 8'h10);
        hold(8'd4,   8'h10, 8'h20);
        hold(8'd16,  8'h20, 8'h40);
        hold(8'd100, 8'h40, 8'hA0);
        hold(8'd2,   8'hA0, 8'h16);
        hold(8'd255, 8'h16, 8'hFF);
        hold(8'd3,   8'hFF, 8'h1B);
        hold(8'd0,   8'h1B, 8'h00);
        for (int i = 0; i < 6; i++) begin
            data_in = s_in[i];
            @(negedge clk);
        end
        data_in = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stream", data_out, s_out[i]);
        end
        for (int x = 0; x < 256; x++) begin
            data_in = 8'(x);
            @(negedge clk);
        end
        data_in = 8'h00;
        repeat (10) @(negedge clk);
        repeat (20) begin
            data_in = 8'($urandom_range(1, 255));
            @(negedge clk);
        end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check("reset_async", data_out, 8'h00);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_low", data_out, 8'h00);
        reset_n = 1'b1;
        hold(8'd16, 8'h00, 8'h40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
